gpr_writeback: RTL and testbench
================================

# gpr_writeback

Register-writeback unit driving the single write port of the NPC general-purpose register file. It arbitrates results from the execute unit and the load/store unit into one registered write per cycle, and keeps a per-register pending-write scoreboard. Decode queries the scoreboard to detect RAW hazards before issuing. Writes to x0 are discarded.

## Interface
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- CNT_WIDTH, 2, width of each per-register pending counter; maximum count is 2**CNT_WIDTH-1
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  decode issues an instruction that writes iss_rd
- iss_rd  in  ADDR_WIDTH  destination of the issuing instruction
- iss_ready  out  1  issue accepted; 0 when counter[iss_rd] is at maximum
- exu_valid / exu_ready  in / out  1  execute-result handshake
- exu_rd, exu_data  in  ADDR_WIDTH, DATA_WIDTH  execute result
- lsu_valid / lsu_ready  in / out  1  load-result handshake
- lsu_rd, lsu_data  in  ADDR_WIDTH, DATA_WIDTH  load result
- rf_wen, rf_waddr, rf_wdata  out  1, ADDR_WIDTH, DATA_WIDTH  registered write port to the register file
- rs1_addr, rs2_addr  in  ADDR_WIDTH  decode source-operand queries
- rs1_busy, rs2_busy  out  1  source has an outstanding write
- rs1_fwd_valid, rs2_fwd_valid  out  1  forwarded operand valid
- rs1_fwd_data, rs2_fwd_data  out  DATA_WIDTH  forwarded operand

## Operation
- Arbitration: fixed priority, LSU over EXU. lsu_ready = !rst. exu_ready = !rst && !lsu_valid.
- Accepted result (valid && ready) with rd != 0 is registered onto rf_wen/rf_waddr/rf_wdata next cycle. Result with rd == 0 is accepted and produces no write.
- Scoreboard: counter[r] increments on issue handshake (iss_valid && iss_ready, iss_rd != 0) and decrements on the edge ending a cycle with rf_wen && rf_waddr == r.
- Simultaneous increment and decrement of the same register: counter unchanged.
- Decrement with counter already 0 (protocol violation): counter stays 0; write still performed.
- iss_rd == 0: iss_ready = 1, no counter change.
- rsX_busy = (rsX_addr != 0) && counter[rsX_addr] != 0, subject to the bypass override below. Address 0 is never busy.

## Timing
- Result handshake in cycle N -> rf_wen = 1 in cycle N+1; register file holds the data from cycle N+2.
- Without bypass: rsX_busy falls in cycle N+2 when the counter reaches 0.
- Back-to-back results are sustained at one per cycle.
- Reset values: all counters 0; rf_wen 0, rf_waddr 0, rf_wdata 0; rsX_busy 0; rsX_fwd_valid 0; rsX_fwd_data 0. exu_ready, lsu_ready and iss_ready are 0 during rst.
- A reset asserted mid-operation discards the registered write in flight: rf_wen is 0 on the cycle after rst.

## Configuration
- GPR_WB_BYPASS_EN defined:
  - In cycle N+1, if rf_wen && rf_waddr == rsX_addr != 0 && counter == 1, then rsX_busy = 0, rsX_fwd_valid = 1 and rsX_fwd_data = rf_wdata.
  - Decode can issue a dependent instruction one cycle earlier.
- GPR_WB_BYPASS_EN undefined:
  - rsX_fwd_valid and rsX_fwd_data are tied to 0.
  - Busy follows only the counter.

## Structure
- Package gpr_wb_pkg: ADDR_WIDTH, DATA_WIDTH, NUM_REGS and CNT_WIDTH constants; the counter typedef; the write-port struct type (wen, waddr, wdata).
- Sub-module gpr_scoreboard: counter array, increment/decrement and saturation logic, and the two combinational query ports.
- The top level holds the arbiter, the output write register and the bypass compare.

## Test plan
- Issue rd=5, then 3 cycles later EXU result rd=5 data 0xDEADBEEF:
  - busy on rs1=5 until the write.
  - rf_wen with waddr 5 one cycle after the handshake.
  - busy clears at N+2, or at N+1 with fwd_data 0xDEADBEEF when bypass is on.
- LSU and EXU valid together (rd=3 and rd=4): LSU written first; exu_ready = 0 that cycle; EXU written the following cycle.
- Issue rd=7 three times with no results: counter at 3, a fourth issue sees iss_ready = 0. One retire re-enables issue. Retire three more times: busy clears only after the last one.
- Issue rd=9 in the same cycle as a retiring write to rd=9 with count 1: count stays 1 and busy remains 1.
- Result to rd=0 with data 0x1234: handshake completes, rf_wen stays 0, rs1_addr=0 never reports busy.
- Assert rst for one cycle while a write is in flight: rf_wen is 0 next cycle and all busy and fwd outputs are 0.

Source files
------------

// File: rtl/gpr_wb_pkg.sv
// Shared constants and types for the GPR writeback unit and its scoreboard.
package gpr_wb_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH  = 2;

  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam cnt_t CNT_MAX = '1;

  typedef struct packed {
    logic  wen;
    addr_t waddr;
    data_t wdata;
  } wr_port_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending-write counters. Incremented by accepted issues,
// decremented by the registered write port, saturating at both ends.
// x0 never holds a count.
module gpr_scoreboard
  import gpr_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_en,
  input  logic [ADDR_WIDTH-1:0] inc_addr,
  input  logic                  dec_en,
  input  logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  output logic                  iss_full,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [CNT_WIDTH-1:0]  rs1_cnt,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [CNT_WIDTH-1:0]  rs2_cnt
);

  cnt_t                cnt_q [NUM_REGS];
  cnt_t                cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // One-hot decode of the increment and decrement targets
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[inc_addr] = 1'b1;
    if (dec_en) dec_vec[dec_addr] = 1'b1;
  end

  // Next count per register; a same-cycle inc and dec cancel out
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i] && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
    end
    cnt_d[0] = '0;
  end

  // Counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign iss_full = (cnt_q[iss_addr] == CNT_MAX);
  assign rs1_cnt  = cnt_q[rs1_addr];
  assign rs2_cnt  = cnt_q[rs2_addr];

endmodule

// File: rtl/gpr_writeback.sv
// GPR writeback: LSU-over-EXU result arbitration into one registered write
// per cycle, pending-write scoreboard for decode RAW checks.
// Optional feature macro: GPR_WB_BYPASS_EN forwards the in-flight write to a
// source query whose register has exactly one pending write.
module gpr_writeback
  import gpr_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rs1_fwd_valid,
  output logic                  rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data
);

  wr_port_t wr_q;
  logic     lsu_fire;
  logic     exu_fire;
  logic     iss_fire;
  logic     iss_full;
  cnt_t     rs1_cnt;
  cnt_t     rs2_cnt;

  assign lsu_ready = !rst;
  assign exu_ready = !rst && !lsu_valid;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign exu_fire  = exu_valid && exu_ready;

  // x0 issues never touch the scoreboard, so they are always accepted
  assign iss_ready = !rst && ((iss_rd == '0) || !iss_full);
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  // Register the winning result; results to x0 are accepted but dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
    end else begin
      wr_q.wen <= 1'b0;
      if (lsu_fire && (lsu_rd != '0)) begin
        wr_q.wen   <= 1'b1;
        wr_q.waddr <= lsu_rd;
        wr_q.wdata <= lsu_data;
      end else if (exu_fire && (exu_rd != '0)) begin
        wr_q.wen   <= 1'b1;
        wr_q.waddr <= exu_rd;
        wr_q.wdata <= exu_data;
      end
    end
  end

  assign rf_wen   = wr_q.wen;
  assign rf_waddr = wr_q.waddr;
  assign rf_wdata = wr_q.wdata;

  gpr_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (iss_fire),
    .inc_addr (iss_rd),
    .dec_en   (wr_q.wen),
    .dec_addr (wr_q.waddr),
    .iss_addr (iss_rd),
    .iss_full (iss_full),
    .rs1_addr (rs1_addr),
    .rs1_cnt  (rs1_cnt),
    .rs2_addr (rs2_addr),
    .rs2_cnt  (rs2_cnt)
  );

  // rs1 busy, overridden by the in-flight write when it retires the last pending one
  always_comb begin
    rs1_busy      = !rst && (rs1_addr != '0) && (rs1_cnt != '0);
    rs1_fwd_valid = 1'b0;
    rs1_fwd_data  = '0;
`ifdef GPR_WB_BYPASS_EN
    if (!rst && wr_q.wen && (wr_q.waddr == rs1_addr) && (rs1_addr != '0) &&
        (rs1_cnt == cnt_t'(1))) begin
      rs1_busy      = 1'b0;
      rs1_fwd_valid = 1'b1;
      rs1_fwd_data  = wr_q.wdata;
    end
`endif
  end

  // rs2 busy, same override as rs1
  always_comb begin
    rs2_busy      = !rst && (rs2_addr != '0) && (rs2_cnt != '0);
    rs2_fwd_valid = 1'b0;
    rs2_fwd_data  = '0;
`ifdef GPR_WB_BYPASS_EN
    if (!rst && wr_q.wen && (wr_q.waddr == rs2_addr) && (rs2_addr != '0) &&
        (rs2_cnt == cnt_t'(1))) begin
      rs2_busy      = 1'b0;
      rs2_fwd_valid = 1'b1;
      rs2_fwd_data  = wr_q.wdata;
    end
`endif
  end

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback; expectations adapt to GPR_WB_BYPASS_EN.
module tb_gpr_writeback;

`ifdef GPR_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rs1_fwd_valid;
  logic        rs2_fwd_valid;
  logic [31:0] rs1_fwd_data;
  logic [31:0] rs2_fwd_data;

  int checks = 0;
  int errors = 0;

  logic        exp_busy;
  logic        exp_fv;
  logic [31:0] exp_fd;

  always #5 clk = ~clk;

  gpr_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .iss_ready     (iss_ready),
    .exu_valid     (exu_valid),
    .exu_ready     (exu_ready),
    .exu_rd        (exu_rd),
    .exu_data      (exu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = '0;
    exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    tick(); tick();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen: got %0b want 0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0h want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata: got %0h want 0", rf_wdata); end
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %0b want 0", lsu_ready); end
    checks++; if (exu_ready !== 1'b0) begin errors++; $display("FAIL reset_exu_ready: got %0b want 0", exu_ready); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL reset_iss_ready: got %0b want 0", iss_ready); end
    checks++; if ({rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid} !== 4'b0000) begin errors++; $display("FAIL reset_busy_fwd: got %b want 0000", {rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid}); end
    checks++; if ({rs1_fwd_data, rs2_fwd_data} !== 64'd0) begin errors++; $display("FAIL reset_fwd_data: got %0h want 0", {rs1_fwd_data, rs2_fwd_data}); end
    rst = 1'b0;
    #1;
    checks++; if ({lsu_ready, exu_ready, iss_ready} !== 3'b111) begin errors++; $display("FAIL post_reset_ready: got %b want 111", {lsu_ready, exu_ready, iss_ready}); end
  endtask

  task automatic test_raw_hazard();
    tick();
    iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL raw_iss_ready: got %0b want 1", iss_ready); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL raw_busy_before_issue: got %0b want 0", rs1_busy); end
    tick();
    iss_valid = 1'b0;
    #1;
    checks++; if ({rs1_busy, rs2_busy} !== 2'b11) begin errors++; $display("FAIL raw_busy_after_issue: got %b want 11", {rs1_busy, rs2_busy}); end
    tick(); tick();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    #1;
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL raw_exu_ready: got %0b want 1", exu_ready); end
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL raw_busy_at_result: got %0b want 1", rs1_busy); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL raw_wen_early: got %0b want 0", rf_wen); end
    tick();
    exu_valid = 1'b0;
    #1;
    exp_busy = BYP ? 1'b0 : 1'b1;
    exp_fv   = BYP;
    exp_fd   = BYP ? 32'hDEADBEEF : 32'h0;
    checks++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd5}) begin errors++; $display("FAIL raw_write: got wen=%0b addr=%0d want wen=1 addr=5", rf_wen, rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_wdata: got %0h want deadbeef", rf_wdata); end
    checks++; if ({rs1_busy, rs2_busy} !== {exp_busy, exp_busy}) begin errors++; $display("FAIL raw_busy_n1: got %b want %b", {rs1_busy, rs2_busy}, {exp_busy, exp_busy}); end
    checks++; if ({rs1_fwd_valid, rs2_fwd_valid} !== {exp_fv, exp_fv}) begin errors++; $display("FAIL raw_fwd_valid_n1: got %b want %b", {rs1_fwd_valid, rs2_fwd_valid}, {exp_fv, exp_fv}); end
    checks++; if (rs1_fwd_data !== exp_fd) begin errors++; $display("FAIL raw_fwd_data_n1: got %0h want %0h", rs1_fwd_data, exp_fd); end
    tick();
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL raw_wen_n2: got %0b want 0", rf_wen); end
    checks++; if ({rs1_busy, rs2_busy, rs1_fwd_valid} !== 3'b000) begin errors++; $display("FAIL raw_clear_n2: got %b want 000", {rs1_busy, rs2_busy, rs1_fwd_valid}); end
  endtask

  task automatic test_priority();
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33333333;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h44444444;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    checks++; if ({lsu_ready, exu_ready} !== 2'b10) begin errors++; $display("FAIL prio_ready: got %b want 10", {lsu_ready, exu_ready}); end
    tick();
    lsu_valid = 1'b0;
    #1;
    checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33333333}) begin errors++; $display("FAIL prio_lsu_write: got wen=%0b addr=%0d data=%0h want 1/3/33333333", rf_wen, rf_waddr, rf_wdata); end
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL prio_exu_ready_after: got %0b want 1", exu_ready); end
    tick();
    exu_valid = 1'b0;
    #1;
    checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44444444}) begin errors++; $display("FAIL prio_exu_write: got wen=%0b addr=%0d data=%0h want 1/4/44444444", rf_wen, rf_waddr, rf_wdata); end
    tick();
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL prio_wen_idle: got %0b want 0", rf_wen); end
    // unpaired retires leave the counters at 0
    checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin errors++; $display("FAIL prio_underflow_busy: got %b want 00", {rs1_busy, rs2_busy}); end
  endtask

  task automatic test_saturate();
    tick();
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_issue0: got %0b want 1", iss_ready); end
    tick(); #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_issue1: got %0b want 1", iss_ready); end
    tick(); #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_issue2: got %0b want 1", iss_ready); end
    tick();
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h70;
    #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_full: got %0b want 0", iss_ready); end
    tick();
    exu_valid = 1'b0;
    #1;
    checks++; if ({rf_wen, rf_waddr, iss_ready} !== {1'b1, 5'd7, 1'b0}) begin errors++; $display("FAIL sat_retire_inflight: got wen=%0b addr=%0d rdy=%0b want 1/7/0", rf_wen, rf_waddr, iss_ready); end
    tick(); #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_reenabled: got %0b want 1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h71;
    #1;
    checks++; if ({iss_ready, rs1_busy} !== 2'b01) begin errors++; $display("FAIL sat_refilled: got rdy/busy=%b want 01", {iss_ready, rs1_busy}); end
    tick();
    exu_data = 32'h72;
    #1;
    checks++; if ({rf_wen, rf_wdata, rs1_busy} !== {1'b1, 32'h71, 1'b1}) begin errors++; $display("FAIL sat_b2b_1: got wen=%0b data=%0h busy=%0b want 1/71/1", rf_wen, rf_wdata, rs1_busy); end
    tick();
    exu_data = 32'h73;
    #1;
    checks++; if ({rf_wen, rf_wdata, rs1_busy} !== {1'b1, 32'h72, 1'b1}) begin errors++; $display("FAIL sat_b2b_2: got wen=%0b data=%0h busy=%0b want 1/72/1", rf_wen, rf_wdata, rs1_busy); end
    tick();
    exu_valid = 1'b0;
    #1;
    exp_busy = BYP ? 1'b0 : 1'b1;
    exp_fv   = BYP;
    exp_fd   = BYP ? 32'h73 : 32'h0;
    checks++; if ({rf_wen, rf_wdata} !== {1'b1, 32'h73}) begin errors++; $display("FAIL sat_b2b_3: got wen=%0b data=%0h want 1/73", rf_wen, rf_wdata); end
    checks++; if ({rs1_busy, rs1_fwd_valid, rs1_fwd_data} !== {exp_busy, exp_fv, exp_fd}) begin errors++; $display("FAIL sat_last_retire: got busy=%0b fv=%0b fd=%0h want %0b/%0b/%0h", rs1_busy, rs1_fwd_valid, rs1_fwd_data, exp_busy, exp_fv, exp_fd); end
    tick(); #1;
    checks++; if ({rs1_busy, iss_ready} !== 2'b01) begin errors++; $display("FAIL sat_drained: got busy/rdy=%b want 01", {rs1_busy, iss_ready}); end
  endtask

  task automatic test_same_cycle();
    tick();
    rs1_addr = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
    tick();
    exu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    checks++; if ({rf_wen, rf_waddr, iss_ready} !== {1'b1, 5'd9, 1'b1}) begin errors++; $display("FAIL same_setup: got wen=%0b addr=%0d rdy=%0b want 1/9/1", rf_wen, rf_waddr, iss_ready); end
    tick();
    iss_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h9A;
    #1;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL same_busy_kept: got %0b want 1", rs1_busy); end
    tick();
    exu_valid = 1'b0;
    tick(); #1;
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL same_count_was_one: got %0b want 0", rs1_busy); end
  endtask

  task automatic test_x0();
    tick();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h1234;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    checks++; if ({exu_ready, iss_ready} !== 2'b11) begin errors++; $display("FAIL x0_handshake: got %b want 11", {exu_ready, iss_ready}); end
    tick();
    exu_valid = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_no_write: got %0b want 0", rf_wen); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_never_busy: got %0b want 0", rs1_busy); end
    iss_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    tick();
    rs1_addr = 5'd10; rs2_addr = 5'd10;
    iss_valid = 1'b1; iss_rd = 5'd10;
    tick();
    exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hA0A0A0A0;
    tick();
    iss_valid = 1'b0; exu_valid = 1'b0;
    #1;
    checks++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd10}) begin errors++; $display("FAIL rst_inflight_setup: got wen=%0b addr=%0d want 1/10", rf_wen, rf_waddr); end
    exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hB0B0B0B0;
    rst = 1'b1;
    #1;
    checks++; if ({exu_ready, lsu_ready, iss_ready} !== 3'b000) begin errors++; $display("FAIL rst_inflight_ready: got %b want 000", {exu_ready, lsu_ready, iss_ready}); end
    tick();
    rst = 1'b0;
    exu_valid = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_inflight_wen: got %0b want 0", rf_wen); end
    checks++; if ({rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid} !== 4'b0000) begin errors++; $display("FAIL rst_inflight_busy_fwd: got %b want 0000", {rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid}); end
    checks++; if ({rs1_fwd_data, rs2_fwd_data} !== 64'd0) begin errors++; $display("FAIL rst_inflight_fwd_data: got %0h want 0", {rs1_fwd_data, rs2_fwd_data}); end
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_priority();
    test_saturate();
    test_same_cycle();
    test_x0();
    test_reset_inflight();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
